// File: rtl/rd_seq_pkg.sv
// Shared types and helpers for the read-sequencing arbiter.
//   rd_state_t : arbiter FSM encoding
//   id_w(n)    : index width for n items, never less than one bit
package rd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    GAP
  } rd_state_t;

  function automatic int unsigned id_w(input int unsigned n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rd_seq_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   i_req : request vector
//   i_ptr : index with the highest priority this round
//   o_any : at least one request is set
//   o_win : first set request scanning upward from i_ptr, with wrap
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_any,
  output logic [IW-1:0] o_win
);

  logic [IW:0] w_sum;
  logic [IW:0] w_pos;

  // Scan from the farthest offset down to offset 0 so the nearest request
  // to the pointer is the last one written and therefore wins.
  always_comb begin
    o_any = 1'b0;
    o_win = '0;
    w_sum = '0;
    w_pos = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      w_pos = (w_sum >= (IW+1)'(N)) ? w_sum - (IW+1)'(N) : w_sum;
      if (i_req[w_pos[IW-1:0]]) begin
        o_any = 1'b1;
        o_win = w_pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rd_seq_arbiter.sv
// Round-robin arbiter sharing one synchronous memory read port.
//   i_clk, i_rst   : clock (posedge), asynchronous active-high reset
//   i_req          : per-requester level request
//   i_req_addr     : requester i address in [i*ADDR_W +: ADDR_W]
//   o_gnt          : one-hot single-cycle accept pulse
//   o_rd, o_addr   : memory read strobe (HOLD cycles) and stable address
//   i_mem_rdata    : memory data, valid in the last rd cycle
//   o_rvalid       : single-cycle pulse, o_rdata/o_rid valid
//   o_rid, o_rdata : owner of the captured data, captured data
module rd_seq_arbiter
  import rd_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned HOLD    = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic                        o_rd,
  output logic [ADDR_W-1:0]           o_addr,
  input  logic [DATA_W-1:0]           i_mem_rdata,
  output logic                        o_rvalid,
  output logic [id_w(NUM_REQ)-1:0]    o_rid,
  output logic [DATA_W-1:0]           o_rdata
);

  localparam int unsigned ID_W  = id_w(NUM_REQ);
  localparam int unsigned CNT_W = id_w(HOLD);

  rd_state_t          r_state,  w_state_nxt;
  logic [ID_W-1:0]    r_ptr,    w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
  logic [ID_W-1:0]    r_cur_id, w_cur_id_nxt;
  logic [NUM_REQ-1:0] r_gnt,    w_gnt_nxt;
  logic               r_rd,     w_rd_nxt;
  logic [ADDR_W-1:0]  r_addr,   w_addr_nxt;
  logic               r_rvalid, w_rvalid_nxt;
  logic [ID_W-1:0]    r_rid,    w_rid_nxt;
  logic [DATA_W-1:0]  r_rdata,  w_rdata_nxt;

  logic               w_any;
  logic [ID_W-1:0]    w_win;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_win (w_win)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    w_cur_id_nxt = r_cur_id;
    w_gnt_nxt    = '0;
    w_rd_nxt     = r_rd;
    w_addr_nxt   = r_addr;
    w_rvalid_nxt = 1'b0;
    w_rid_nxt    = r_rid;
    w_rdata_nxt  = r_rdata;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt_nxt[w_win] = 1'b1;
          w_rd_nxt         = 1'b1;
          w_addr_nxt       = i_req_addr[w_win*ADDR_W +: ADDR_W];
          w_cur_id_nxt     = w_win;
          w_cnt_nxt        = '0;
          w_ptr_nxt        = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
          w_state_nxt      = READ;
        end
      end
      READ: begin
        // Requests are not looked at here; addr is frozen until rd drops.
        if (r_cnt == CNT_W'(HOLD - 1)) begin
          w_rd_nxt     = 1'b0;
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = i_mem_rdata;
          w_rid_nxt    = r_cur_id;
          w_state_nxt  = GAP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        // Mandatory rd-low cycle; pending requests wait for IDLE.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_cur_id <= '0;
      r_gnt    <= '0;
      r_rd     <= 1'b0;
      r_addr   <= '0;
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cur_id <= w_cur_id_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rd     <= w_rd_nxt;
      r_addr   <= w_addr_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rid    <= w_rid_nxt;
      r_rdata  <= w_rdata_nxt;
    end
  end

  assign o_gnt    = r_gnt;
  assign o_rd     = r_rd;
  assign o_addr   = r_addr;
  assign o_rvalid = r_rvalid;
  assign o_rid    = r_rid;
  assign o_rdata  = r_rdata;

endmodule

// File: tb/tb_rd_seq_arbiter.sv
// Self-checking bench for rd_seq_arbiter (default build, HOLD=2).
module tb_rd_seq_arbiter;
  import rd_seq_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned HOLD    = 2;
  localparam int unsigned ID_W    = id_w(NUM_REQ);

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rd;
  logic [ADDR_W-1:0]         addr;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      rvalid;
  logic [ID_W-1:0]           rid;
  logic [DATA_W-1:0]         rdata;

  always #5 clk = ~clk;

  rd_seq_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .HOLD    (HOLD)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_req_addr  (req_addr),
    .o_gnt       (gnt),
    .o_rd        (rd),
    .o_addr      (addr),
    .i_mem_rdata (mem_rdata),
    .o_rvalid    (rvalid),
    .o_rid       (rid),
    .o_rdata     (rdata)
  );

  // Memory model: data only valid in the last rd cycle, junk otherwise.
  function automatic logic [DATA_W-1:0] fmem(input logic [ADDR_W-1:0] a);
    return a ^ 8'h5A;
  endfunction

  int age;
  always @(posedge clk or posedge rst) begin
    if (rst)     age <= 0;
    else if (rd) age <= age + 1;
    else         age <= 0;
  end
  assign mem_rdata = (rd && age == int'(HOLD) - 1) ? fmem(addr) : 8'hEE;

  // Checking infrastructure
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] a;
  } exp_t;

  exp_t q_gnt[$];
  exp_t q_rv[$];

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a);
    exp_t e;
    e.id = id;
    e.a  = a;
    q_gnt.push_back(e);
    q_rv.push_back(e);
  endtask

  // Monitor: consumes the scoreboard on gnt and rvalid, checks rd shape.
  int cyc = 0;
  int n_gnt_seen = 0;
  initial begin
    exp_t e;
    logic [ADDR_W-1:0] cur_addr = '0;
    int gnt_cyc = 0;
    int run_len = 0;
    int last_rise = -1;
    bit prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        run_len   = 0;
        prev_rd   = 1'b0;
        last_rise = -1;
      end else begin
        if (gnt != '0) begin
          n_gnt_seen++;
          if (q_gnt.size() == 0) begin
            chk("unexpected_gnt", 32'(gnt), 32'd0);
          end else begin
            e = q_gnt.pop_front();
            chk("gnt_id", 32'(gnt), 32'(1) << e.id);
            chk("gnt_addr", 32'(addr), 32'(e.a));
            chk("gnt_rd", 32'(rd), 32'd1);
            cur_addr = e.a;
            gnt_cyc  = cyc;
          end
        end
        if (rd) begin
          if (!prev_rd) begin
            if (last_rise >= 0) chk("rise_spacing_min", 32'(cyc - last_rise >= int'(HOLD) + 2), 32'd1);
            last_rise = cyc;
          end
          run_len++;
          chk("addr_stable", 32'(addr), 32'(cur_addr));
        end else if (prev_rd) begin
          chk("rd_len", 32'(run_len), 32'(HOLD));
          run_len = 0;
        end
        prev_rd = rd;
        if (rvalid) begin
          if (q_rv.size() == 0) begin
            chk("unexpected_rvalid", 32'(rvalid), 32'd0);
          end else begin
            e = q_rv.pop_front();
            chk("rid", 32'(rid), 32'(e.id));
            chk("rdata", 32'(rdata), 32'(fmem(e.a)));
            chk("rvalid_latency", 32'(cyc - gnt_cyc), 32'(HOLD));
          end
        end
      end
    end
  end

  task automatic wait_gnt(input string name, output int at);
    at = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (gnt != '0) begin
        at = int'($time / 10);
        return;
      end
    end
    chk({name, "_gnt_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 50 && q_rv.size() != 0; t++) @(negedge clk);
    if (q_rv.size() != 0) begin
      chk({name, "_drain_timeout"}, 32'(q_rv.size()), 32'd0);
      q_rv.delete();
      q_gnt.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic set_addrs(input logic [ADDR_W-1:0] base);
    for (int i = 0; i < int'(NUM_REQ); i++) req_addr[i*ADDR_W +: ADDR_W] = base + ADDR_W'(i);
  endtask

  // Assertions
  a_addr_hold: assert property (@(posedge clk) disable iff (rst) $rose(rd) |=> $stable(addr))
    else $error("assertion a_addr_hold violated");
  a_rd_len: assert property (@(posedge clk) disable iff (rst) rd |-> ##HOLD !rd)
    else $error("assertion a_rd_len violated");
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("assertion a_gnt_onehot violated");
  a_rvalid_gap: assert property (@(posedge clk) disable iff (rst) rvalid |-> !rd)
    else $error("assertion a_rvalid_gap violated");

  typedef struct {
    logic [NUM_REQ-1:0] req;
    logic [ADDR_W-1:0]  base;
    logic [ID_W-1:0]    exp_id;
    logic [ADDR_W-1:0]  exp_addr;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    int   t_at[5];
    int   tmp;
    int   g0;

    // Expected winners follow the round-robin pointer from reset (ptr=0).
    tbl[0] = '{4'b0010, 8'h01, 2'd1, 8'h02};
    tbl[1] = '{4'b1001, 8'h20, 2'd3, 8'h23};
    tbl[2] = '{4'b0110, 8'h40, 2'd1, 8'h41};
    tbl[3] = '{4'b0101, 8'h60, 2'd2, 8'h62};
    tbl[4] = '{4'b0011, 8'h80, 2'd0, 8'h80};
    tbl[5] = '{4'b1000, 8'hA0, 2'd3, 8'hA3};

    // Reset values
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table of single-grant transactions
    for (int i = 0; i < 6; i++) begin
      set_addrs(tbl[i].base);
      push_exp(tbl[i].exp_id, tbl[i].exp_addr);
      req = tbl[i].req;
      wait_gnt("tbl", tmp);
      req = '0;
      drain("tbl");
    end

    // All four requesting continuously: 0,1,2,3,0 at HOLD+2 spacing
    req_addr = {8'h09, 8'h07, 8'h04, 8'h02};
    push_exp(2'd0, 8'h02);
    push_exp(2'd1, 8'h04);
    push_exp(2'd2, 8'h07);
    push_exp(2'd3, 8'h09);
    push_exp(2'd0, 8'h02);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_gnt("b2b", t_at[i]);
    req = '0;
    for (int i = 1; i < 5; i++) chk("b2b_spacing", 32'(t_at[i] - t_at[i-1]), 32'(HOLD + 2));
    drain("b2b");

    // Address change during READ is ignored (ptr=1, only requester 0)
    req_addr[0 +: ADDR_W] = 8'h07;
    push_exp(2'd0, 8'h07);
    req = 4'b0001;
    wait_gnt("addr_chg", tmp);
    req = '0;
    req_addr[0 +: ADDR_W] = 8'h09;
    drain("addr_chg");

    // One-cycle pulse of req[2] during READ is not served (ptr=1)
    g0 = n_gnt_seen;
    req_addr[1*ADDR_W +: ADDR_W] = 8'h11;
    req_addr[2*ADDR_W +: ADDR_W] = 8'h22;
    push_exp(2'd1, 8'h11);
    req = 4'b0010;
    wait_gnt("pulse", tmp);
    req = '0;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    drain("pulse");
    repeat (8) @(negedge clk);
    chk("pulse_gnt_count", 32'(n_gnt_seen - g0), 32'd1);

    // Reset during the second rd cycle drops the read (ptr=2 -> requester 3)
    req_addr[3*ADDR_W +: ADDR_W] = 8'h33;
    push_exp(2'd3, 8'h33);
    req = 4'b1000;
    wait_gnt("rst_mid", tmp);
    req = '0;
    @(posedge clk);
    #1;
    chk("rst_mid_rd_before", 32'(rd), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_rd", 32'(rd), 32'd0);
    chk("rst_mid_gnt", 32'(gnt), 32'd0);
    chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
    q_rv.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_addrs(8'h50);
    push_exp(2'd1, 8'h51);
    push_exp(2'd2, 8'h52);
    req = 4'b0110;
    wait_gnt("post_rst", tmp);
    req = 4'b0100;
    wait_gnt("post_rst", tmp);
    req = '0;
    drain("post_rst");

    chk("scoreboard_empty", 32'(q_gnt.size() + q_rv.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
